// File: rtl/riscv_fetch_fifo_gen.sv
// Instruction fetch buffer: circular word store with RVC halfword realignment,
// optional empty-FIFO bypass, occupancy/almost-full and sticky overflow status.
module riscv_fetch_fifo_gen #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int AF_LEVEL = 2,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic [31:0]                in_addr_i,
  input  logic [31:0]                in_rdata_i,
  input  logic [TAG_W-1:0]           in_rtag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_rdata_o,
  output logic [TAG_W-1:0]           out_rtag_o,
  output logic [31:0]                out_addr_o,
  output logic                       out_is_compressed_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TH = TAG_W / 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [29:0]      r_mem_addr [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_hw_off;
  logic          r_first;
  logic          r_overflow;

  logic [PW-1:0]    w_rd_nxt;
  logic             w_count_zero;
  logic             w_count_one;
  logic             w_bypass0;
  logic             w_bypass1;
  logic [29:0]      w_w0_addr;
  logic [31:0]      w_w0_data;
  logic [TAG_W-1:0] w_w0_tag;
  logic             w_w0_valid;
  logic [15:0]      w_w1_data;
  logic [TAG_W-1:0] w_w1_tag;
  logic             w_w1_valid;
  logic             w_hw;
  logic             w_comp;
  logic [TAG_W-1:0] w_tag_hi;
  logic             w_push;
  logic             w_accept;
  logic             w_pop;
  logic [TAG_W:0]   w_unused;

  assign w_rd_nxt     = r_rd_ptr + PW'(1);
  assign w_count_zero = (r_count == {CW{1'b0}});
  assign w_count_one  = (r_count == CW'(1));
  // The input word stands in for a missing stored word only when bypass is enabled.
  assign w_bypass0    = (BYPASS != 0) && w_count_zero && in_valid_i;
  assign w_bypass1    = (BYPASS != 0) && w_count_one && in_valid_i;

  // Select the head word and its successor, from storage or the input port.
  always_comb begin
    w_w0_addr  = r_mem_addr[r_rd_ptr];
    w_w0_data  = r_mem_data[r_rd_ptr];
    w_w0_tag   = r_mem_tag[r_rd_ptr];
    w_w1_data  = r_mem_data[w_rd_nxt][15:0];
    w_w1_tag   = r_mem_tag[w_rd_nxt];
    w_w0_valid = w_bypass0 || !w_count_zero;
    w_w1_valid = w_bypass1 || (r_count >= CW'(2));
    if (w_bypass0) begin
      w_w0_addr = in_addr_i[31:2];
      w_w0_data = in_rdata_i;
      w_w0_tag  = in_rtag_i;
    end else begin
      w_w0_addr = r_mem_addr[r_rd_ptr];
    end
    if (w_bypass1) begin
      w_w1_data = in_rdata_i[15:0];
      w_w1_tag  = in_rtag_i;
    end else begin
      w_w1_data = r_mem_data[w_rd_nxt][15:0];
    end
  end

  // A bypassed first word has not loaded hw_off yet, so take its offset from the address.
  always_comb begin
    w_hw   = r_hw_off;
    w_comp = 1'b0;
    if (w_bypass0 && r_first) begin
      w_hw = in_addr_i[1];
    end else begin
      w_hw = r_hw_off;
    end
    if (w_hw) begin
      w_comp = (w_w0_data[17:16] != 2'b11);
    end else begin
      w_comp = (w_w0_data[1:0] != 2'b11);
    end
  end

  generate
    if (TAG_W > 1) begin : g_tag_split
      assign w_tag_hi = {w_w1_tag[TH-1:0], w_w0_tag[TAG_W-1:TH]};
    end else begin : g_tag_single
      assign w_tag_hi = w_w0_tag;
    end
  endgenerate

  // Splice the output instruction and its tag from the two candidate words.
  always_comb begin
    out_rdata_o = w_w0_data;
    out_rtag_o  = w_w0_tag;
    if (w_hw) begin
      out_rdata_o = {w_w1_data, w_w0_data[31:16]};
      out_rtag_o  = w_tag_hi;
    end else begin
      out_rdata_o = w_w0_data;
      out_rtag_o  = w_w0_tag;
    end
  end

  assign out_valid_o         = w_w0_valid && (!w_hw || w_comp || w_w1_valid);
  assign out_is_compressed_o = w_comp;
  assign out_addr_o          = {w_w0_addr, w_hw, 1'b0};
  assign in_ready_o          = (r_count < DEPTH_C);
  assign count_o             = r_count;
  assign almost_full_o       = (r_count >= AF_C);
  assign overflow_o          = r_overflow;

  // An aligned compressed accept leaves its word in place for the upper half.
  assign w_push   = in_valid_i && in_ready_o && !clear_i;
  assign w_accept = out_valid_o && out_ready_i && !clear_i;
  assign w_pop    = w_accept && (w_hw || !w_comp);
  assign w_unused = {in_addr_i[0], w_w1_tag};

  // Word storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= in_addr_i[31:2];
      r_mem_data[r_wr_ptr] <= in_rdata_i;
      r_mem_tag[r_wr_ptr]  <= in_rtag_i;
    end
  end

  // Pointers, occupancy, halfword offset and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= {PW{1'b0}};
      r_wr_ptr   <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_hw_off   <= 1'b0;
      r_first    <= 1'b1;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_hw_off <= 1'b0;
      r_first  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_first  <= 1'b0;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // The next offset flips exactly when the consumed instruction was compressed.
      if (w_accept) begin
        r_hw_off <= w_hw ^ w_comp;
      end else if (w_push && r_first) begin
        r_hw_off <= in_addr_i[1];
      end
      if (in_valid_i && !in_ready_o) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_fifo_gen.sv
// Scoreboard bench: a halfword-stream model turns accepted pushes into expected
// instructions; a separate monitor pops and compares on every handshake.
module tb_riscv_fetch_fifo_gen;

  localparam int DEPTH    = 4;
  localparam int TAG_W    = 4;
  localparam int AF_LEVEL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_i;
  logic [31:0] in_addr_i;
  logic [31:0] in_rdata_i;
  logic [3:0]  in_rtag_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [3:0]  out_rtag_o;
  logic [31:0] out_addr_o;
  logic        out_is_compressed_o;
  logic [2:0]  count_o;
  logic        almost_full_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  riscv_fetch_fifo_gen #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .AF_LEVEL(AF_LEVEL), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .in_addr_i(in_addr_i), .in_rdata_i(in_rdata_i), .in_rtag_i(in_rtag_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rdata_o(out_rdata_o), .out_rtag_o(out_rtag_o), .out_addr_o(out_addr_o),
    .out_is_compressed_o(out_is_compressed_o), .count_o(count_o),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  tag;
    logic        comp;
    int          nh;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  t;
    logic [31:0] a;
  } half_t;

  exp_t  expq[$];
  half_t hq[$];
  int    wq[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_first = 1'b1;
  bit    m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  function automatic void model_parse();
    bit   go = 1'b1;
    exp_t e;
    while (go && hq.size() > 0) begin
      if (hq[0].d[1:0] != 2'b11) begin
        e.data = {16'h0000, hq[0].d};
        e.addr = hq[0].a;
        e.tag  = {2'b00, hq[0].t};
        e.comp = 1'b1;
        e.nh   = 1;
        expq.push_back(e);
        void'(hq.pop_front());
      end else if (hq.size() >= 2) begin
        e.data = {hq[1].d, hq[0].d};
        e.addr = hq[0].a;
        e.tag  = {hq[1].t, hq[0].t};
        e.comp = 1'b0;
        e.nh   = 2;
        expq.push_back(e);
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else begin
        go = 1'b0;
      end
    end
  endfunction

  function automatic void model_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    half_t h;
    bool_skip: begin
      if (!(m_first && a[1])) begin
        h.d = d[15:0]; h.t = t[1:0]; h.a = {a[31:2], 2'b00};
        hq.push_back(h);
      end
    end
    h.d = d[31:16]; h.t = t[3:2]; h.a = {a[31:2], 2'b10};
    hq.push_back(h);
    wq.push_back((m_first && a[1]) ? 1 : 2);
    m_first = 1'b0;
    model_parse();
  endfunction

  function automatic void model_clear();
    expq.delete();
    hq.delete();
    wq.delete();
    m_first = 1'b1;
  endfunction

  task automatic cyc(input bit clr, input bit vld, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] t, input bit rdy);
    @(negedge clk);
    clear_i     = clr;
    in_valid_i  = vld;
    in_addr_i   = a;
    in_rdata_i  = d;
    in_rtag_i   = t;
    out_ready_i = rdy;
    #1;
    chk("count", {29'd0, count_o}, wq.size());
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, (wq.size() < DEPTH)});
    chk("almost_full", {31'd0, almost_full_o}, {31'd0, (wq.size() >= AF_LEVEL)});
    chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
    if (clr) begin
      model_clear();
    end else if (vld) begin
      if (wq.size() < DEPTH) model_push(a, d, t);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
  endtask

  // Monitor: checks valid against the scoreboard and compares each accepted instruction.
  always @(negedge clk) begin : mon
    exp_t e;
    int   n;
    #2;
    if (!rst && !clear_i) begin
      checks++;
      if (out_valid_o !== (expq.size() > 0)) begin
        errors++;
        $display("FAIL out_valid actual %b required %b", out_valid_o, (expq.size() > 0));
      end
      if (out_valid_o === 1'b1 && out_ready_i && expq.size() > 0) begin
        e = expq.pop_front();
        chk("comp", {31'd0, out_is_compressed_o}, {31'd0, e.comp});
        chk("addr", out_addr_o, e.addr);
        if (e.comp) begin
          chk("data16", {16'h0, out_rdata_o[15:0]}, e.data);
          chk("tag16", {30'd0, out_rtag_o[1:0]}, {28'd0, e.tag});
        end else begin
          chk("data32", out_rdata_o, e.data);
          chk("tag32", {28'd0, out_rtag_o}, {28'd0, e.tag});
        end
        n = e.nh;
        while (n > 0 && wq.size() > 0) begin
          wq[0] = wq[0] - 1;
          if (wq[0] == 0) void'(wq.pop_front());
          n--;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_addr_i = 32'h0; in_rdata_i = 32'h0; in_rtag_i = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_af", {31'd0, almost_full_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cyc(1'b0, 1'b1, 32'h100, 32'h00000000, 4'h3, 1'b0);
    cyc(1'b0, 1'b1, 32'h104, 32'h00000013, 4'h5, 1'b0);
    idle(4);
    cyc(1'b0, 1'b1, 32'h200, 32'h45014501, 4'h9, 1'b1);
    idle(3);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h302, 32'h05130000, 4'hC, 1'b1);
    cyc(1'b0, 1'b1, 32'h304, 32'h00000005, 4'h6, 1'b1);
    idle(3);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 32'(32'h600 + 4 * i), 32'(32'h00000093 | (i << 7)), 4'(i), 1'b0);
    idle(8);
    cyc(1'b0, 1'b1, 32'h400, 32'h00A00093, 4'hA, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 32'(32'h700 + 4 * i), 32'h00000013, 4'h1, 1'b0);
    cyc(1'b1, 1'b1, 32'h70C, 32'h00000013, 4'h2, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h502, 32'h45010000, 4'hF, 1'b1);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 60) == 0, ($urandom % 3) != 0, $urandom, $urandom,
          4'($urandom_range(0, 15)), ($urandom % 10) < 7);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
